// File: rtl/invaes_ctrl.sv
// rtl/invaes_ctrl.sv - inverse-AES datapath sequencer
//
// Synchronises the SPI master's load strobe. After load falls (key and
// cyphertext are shifted in), it steps through key expansion, the initial
// AddRoundKey, NR-1 inverse rounds and the final round, then raises done.
//
// Parameters:
//   K           key length in bits (128/192/256); NR = 10/12/14 is derived
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   load        SPI master load strobe (asynchronous), high while shifting in
//   keyexp_en   key schedule computes round key round_idx
//   ark_en      datapath: state <= cyphertext ^ roundkey[round_idx]
//   round_en    datapath: one inverse round with roundkey[round_idx]
//   last_round  qualifies round_en: skip InvMixColumns
//   round_idx   round-key index for the current cycle
//   busy        high in KEYEXP/INIT/ROUNDS/FINAL
//   done        plaintext valid; held until the next load rise
//   cyc_count   latency of the last run (only with INVAES_CYCLE_CNT_EN)
//
// Build option: define INVAES_CYCLE_CNT_EN to add the cyc_count port.

module invaes_ctrl #(
    parameter int K = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    output logic        keyexp_en,
    output logic        ark_en,
    output logic        round_en,
    output logic        last_round,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
`ifdef INVAES_CYCLE_CNT_EN
    ,
    output logic [15:0] cyc_count
`endif
);

    localparam logic [3:0] NR = (K == 256) ? 4'd14 : (K == 192) ? 4'd12 : 4'd10;

    if (K != 128 && K != 192 && K != 256) begin : g_bad_k
        $error("invaes_ctrl: K must be 128, 192 or 256");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KEYEXP,
        S_INIT,
        S_ROUNDS,
        S_FINAL,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_idx_q, round_idx_d;
    logic       load_meta_q, load_s_q, load_q;
    logic       rise, fall;
    logic       keyexp_en_q, keyexp_en_d;
    logic       ark_en_q, ark_en_d;
    logic       round_en_q, round_en_d;
    logic       last_round_q, last_round_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        rise        = load_s_q & ~load_q;
        fall        = ~load_s_q & load_q;
        state_d     = state_q;
        round_idx_d = round_idx_q;

        // A new load while working abandons the run; nothing gets flagged done.
        if (rise && (state_q == S_KEYEXP || state_q == S_INIT ||
                     state_q == S_ROUNDS || state_q == S_FINAL)) begin
            state_d     = S_LOAD;
            round_idx_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise) state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (fall) begin
                        state_d     = S_KEYEXP;
                        round_idx_d = 4'd1;
                    end
                end
                S_KEYEXP: begin
                    if (round_idx_q == NR) state_d = S_INIT;
                    else                   round_idx_d = round_idx_q + 4'd1;
                end
                S_INIT: begin
                    state_d     = S_ROUNDS;
                    round_idx_d = NR - 4'd1;
                end
                S_ROUNDS: begin
                    if (round_idx_q == 4'd1) begin
                        state_d     = S_FINAL;
                        round_idx_d = 4'd0;
                    end else begin
                        round_idx_d = round_idx_q - 4'd1;
                    end
                end
                S_FINAL: begin
                    state_d     = S_DONE;
                    round_idx_d = 4'd0;
                end
                S_DONE: begin
                    if (rise) begin
                        state_d     = S_LOAD;
                        round_idx_d = 4'd0;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    round_idx_d = 4'd0;
                end
            endcase
        end

        // Outputs are decoded from the next state and registered, so each
        // strobe is a glitch-free Moore decode of the state it accompanies.
        keyexp_en_d  = (state_d == S_KEYEXP);
        ark_en_d     = (state_d == S_INIT);
        round_en_d   = (state_d == S_ROUNDS) || (state_d == S_FINAL);
        last_round_d = (state_d == S_FINAL);
        busy_d       = keyexp_en_d | ark_en_d | round_en_d;
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_meta_q  <= 1'b0;
            load_s_q     <= 1'b0;
            load_q       <= 1'b0;
            state_q      <= S_IDLE;
            round_idx_q  <= 4'd0;
            keyexp_en_q  <= 1'b0;
            ark_en_q     <= 1'b0;
            round_en_q   <= 1'b0;
            last_round_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            load_meta_q  <= load;
            load_s_q     <= load_meta_q;
            load_q       <= load_s_q;
            state_q      <= state_d;
            round_idx_q  <= round_idx_d;
            keyexp_en_q  <= keyexp_en_d;
            ark_en_q     <= ark_en_d;
            round_en_q   <= round_en_d;
            last_round_q <= last_round_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign keyexp_en  = keyexp_en_q;
    assign ark_en     = ark_en_q;
    assign round_en   = round_en_q;
    assign last_round = last_round_q;
    assign round_idx  = round_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef INVAES_CYCLE_CNT_EN
    logic [15:0] cyc_count_q, cyc_count_d;

    // Restarts on KEYEXP entry, counts busy cycles, then holds the last
    // run's latency through DONE and LOAD.
    always_comb begin
        cyc_count_d = cyc_count_q;
        if (state_q == S_LOAD && state_d == S_KEYEXP) begin
            cyc_count_d = 16'd0;
        end else if (busy_q && cyc_count_q != 16'hFFFF) begin
            cyc_count_d = cyc_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_count_q <= 16'd0;
        else          cyc_count_q <= cyc_count_d;
    end

    assign cyc_count = cyc_count_q;
`endif

endmodule
